instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding riscv_core.
// Keeps the fetch PC and issues in-order word requests to instruction memory.
// Returned words go into a small FIFO. The stage holds the FIFO head while the
// core stalls and flushes on a redirect. When no word is available it presents
// a NOP bubble (addi x0,x0,0).
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   // instruction memory request channel
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   // instruction memory response channel (in order)
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   // core side
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        valid_o
);

   localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Counter width leaves headroom so inflight + count never wraps.
   localparam int          CW      = $clog2(DEPTH) + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_rsp_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [31:0]   r_buf_data [DEPTH];
   logic [31:0]   r_buf_pc   [DEPTH];

   logic          w_valid;
   logic          w_pop;
   logic [CW-1:0] w_credit_used;
   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_rsp_fire;
   logic          w_rsp_discard;
   logic          w_push;
   logic [31:0]   w_redirect_pc;

   // Handshake and credit decode. A response is only accepted while a
   // request is outstanding, so stale words after a reset are ignored.
   always_comb begin
      w_valid       = !rst && !redirect_valid_i && (r_count != '0);
      w_pop         = w_valid && !stall_i;
      w_credit_used = r_inflight + r_count - CW'(w_pop);
      w_req_valid   = !rst && !redirect_valid_i && (w_credit_used < DEPTH_C);
      w_req_fire    = w_req_valid && imem_req_ready_i;
      w_rsp_fire    = !rst && imem_rsp_valid_i && (r_inflight != '0);
      w_rsp_discard = w_rsp_fire && (r_drop != '0);
      w_push        = w_rsp_fire && (r_drop == '0) && !redirect_valid_i;
      w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
   end

   assign imem_req_valid_o = w_req_valid;
   assign imem_req_addr_o  = r_fetch_pc;
   assign valid_o          = w_valid;
   assign instruction_o    = w_valid ? r_buf_data[r_rd_ptr] : NOP;
   assign pc_o             = w_valid ? r_buf_pc[r_rd_ptr]   : 32'h0;

   // Fetch PC, response PC, outstanding-request and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
         if (redirect_valid_i) begin
            // Everything still outstanding after this edge is stale.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_drop     <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_rsp_discard) begin
               r_drop <= r_drop - CW'(1);
            end
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO storage: the word and the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_data[r_wr_ptr] <= imem_rsp_data_i;
         r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
      end
   end

   // The request credit rule must make these unreachable.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && (r_count == DEPTH_C)));
   a_inflight_bound : assert property (@(posedge clk) disable iff (rst)
      (r_inflight <= DEPTH_C));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. It contains a variable-latency
// in-order memory model and a scoreboard of expected {pc, word} pairs.
// Entries are queued at request handshake and compared when the core pops one.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0080;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instruction_o;
   logic [31:0] pc_o;
   logic        valid_o;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } exp_t;

   mreq_t mq[$];
   exp_t  sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int lat      = 1;
   int pops     = 0;

   instr_fetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .instruction_o    (instruction_o),
      .pc_o             (pc_o),
      .valid_o          (valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]} | 32'h0000_0003;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
   endtask

   // Memory model: drives the front response once its latency has elapsed.
   always @(negedge clk) begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mem_word(mq[0].addr);
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = 32'h0;
      end
   end

   // Monitor: sampled mid low phase, after inputs have settled for the cycle.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst) begin
         mq.delete();
         sb.delete();
      end else begin
         if (imem_rsp_valid_i && mq.size() > 0) void'(mq.pop_front());
         if (imem_req_valid_o && imem_req_ready_i)
            mq.push_back('{addr: imem_req_addr_o, due: cyc + lat});
         if (redirect_valid_i) begin
            check("redir_valid", 32'(valid_o), 32'h0);
            check("redir_req", 32'(imem_req_valid_o), 32'h0);
            sb.delete();
         end else begin
            if (valid_o && !stall_i) begin
               pops++;
               if (sb.size() == 0) begin
                  check("pop_unexpected", pc_o, 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  $display("pop pc=%08h insn=%08h", pc_o, instruction_o);
                  check("pop_pc", pc_o, e.pc);
                  check("pop_insn", instruction_o, e.insn);
               end
            end
            if (imem_req_valid_o && imem_req_ready_i)
               sb.push_back('{pc: imem_req_addr_o, insn: mem_word(imem_req_addr_o)});
         end
      end
      cyc++;
   end

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   // Wait (bounded) for valid_o, then check the presented pc.
   task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
      int k = 0;
      while (!valid_o && k < 30) begin
         tick();
         k++;
      end
      check({tag, "_valid"}, 32'(valid_o), 32'h1);
      check(tag, pc_o, exp_pc);
   endtask

   // Release reset and measure cycles until the first valid instruction.
   task automatic release_and_measure(input string tag);
      int first = 0;
      @(negedge clk);
      rst = 1'b0;
      #3;
      for (int k = 1; k <= 12 && first == 0; k++) begin
         if (k > 1) tick();
         if (valid_o) first = k;
      end
      check({tag, "_latency"}, 32'(first), 32'd3);
      check({tag, "_pc0"}, pc_o, RST_PC);
      tick();
      check({tag, "_pc1"}, pc_o, RST_PC + 32'd4);
   endtask

   initial begin
      logic [31:0] hp, hi, a0;
      int p0;
      rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
      imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;

      // Reset outputs.
      repeat (3) begin
         tick();
         check("rst_valid", 32'(valid_o), 32'h0);
         check("rst_insn", instruction_o, NOP);
         check("rst_pc", pc_o, 32'h0);
         check("rst_req", 32'(imem_req_valid_o), 32'h0);
      end

      // Reset release: first valid at cycle 3, then one per cycle.
      release_and_measure("boot");
      p0 = pops;
      repeat (8) @(negedge clk);
      #3;
      check("throughput", 32'(pops - p0), 32'd8);

      // Stall: head held, requests stop when credit runs out.
      @(negedge clk);
      stall_i = 1'b1;
      #3;
      hp = pc_o;
      hi = instruction_o;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         check("stall_valid", 32'(valid_o), 32'h1);
         check("stall_pc_hold", pc_o, hp);
         check("stall_insn_hold", instruction_o, hi);
      end
      check("stall_credit_stop", 32'(imem_req_valid_o), 32'h0);
      @(negedge clk);
      stall_i = 1'b0;
      #3;
      check("unstall_head", pc_o, hp);
      tick();
      check("unstall_next", pc_o, hp + 32'd4);

      // Memory not ready: address held, FIFO drains to bubbles.
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      #3;
      a0 = imem_req_addr_o;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         check("notready_addr_hold", imem_req_addr_o, a0);
      end
      check("drain_valid", 32'(valid_o), 32'h0);
      check("drain_insn", instruction_o, NOP);
      check("drain_pc", pc_o, 32'h0);
      @(negedge clk);
      imem_req_ready_i = 1'b1;

      // Latency-3 memory with requests outstanding, redirect to unaligned target.
      lat = 3;
      repeat (6) @(negedge clk);
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      @(negedge clk);
      redirect_valid_i = 1'b0;
      #3;
      wait_valid("redir3_first", 32'h0000_0100);
      tick();
      wait_valid("redir3_second", 32'h0000_0104);

      // Redirect while a response is arriving (latency 1 streaming).
      lat = 1;
      repeat (8) @(negedge clk);
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      @(negedge clk);
      redirect_valid_i = 1'b0;
      #3;
      wait_valid("redir1_first", 32'h0000_0200);
      tick();
      wait_valid("redir1_second", 32'h0000_0204);

      // Back-to-back redirects: the later one wins.
      @(negedge clk);
      redirect_valid_i = 1'b1;
      redirect_pc_i = 32'h0000_0300;
      @(negedge clk);
      redirect_pc_i = 32'h0000_0404;
      @(negedge clk);
      redirect_valid_i = 1'b0;
      #3;
      wait_valid("b2b_first", 32'h0000_0404);

      // Reset mid-operation with a full FIFO and requests outstanding.
      lat = 3;
      @(negedge clk);
      stall_i = 1'b1;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      lat = 1;
      #3;
      check("midrst_valid", 32'(valid_o), 32'h0);
      check("midrst_req", 32'(imem_req_valid_o), 32'h0);
      tick();
      stall_i = 1'b0;
      check("midrst_valid2", 32'(valid_o), 32'h0);
      check("midrst_insn", instruction_o, NOP);
      release_and_measure("restart");

      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
